alu_md: RTL
===========

Name: alu_md

Overview:
- Parametrised successor to the single-cycle integer ALU. Adds the RV32M multiply/divide/remainder operations to the base ALU operation set.
- Executes base ops in one registered cycle. Executes multiply and divide iteratively, one bit per cycle.
- Sits in the execute stage and talks to the pipeline through a valid/ready handshake, so long operations stall the front end.
- A flush input lets the hazard unit kill an in-flight operation.

Parameters:
- WIDTH, 32: operand/result width in bits; must be ≥ 8 and a power of two.
- SHW, $clog2(WIDTH): shift-amount width; shift ops use portb[SHW-1:0].

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  reset, synchronous, active-low.
- flush  in  1  abort current operation and drop any pending result.
- in_valid  in  1  operands and op are valid.
- in_ready  out  1  block can accept an operation.
- op  in  5  0 SLL, 1 SRL, 2 SRA, 3 ADD, 4 SUB, 5 AND, 6 OR, 7 XOR, 8 SLT, 9 SLTU, 16 MUL, 17 MULH, 18 MULHSU, 19 MULHU, 20 DIV, 21 DIVU, 22 REM, 23 REMU; other values are illegal.
- porta  in  WIDTH  operand A (rs1).
- portb  in  WIDTH  operand B (rs2).
- out_valid  out  1  result and flags are valid.
- out_ready  in  1  consumer accepts the result.
- portout  out  WIDTH  result.
- negative  out  1  portout[WIDTH-1].
- zero  out  1  portout == 0.
- overflow  out  1  signed overflow; see Behaviour.
- divzero  out  1  DIV/DIVU/REM/REMU with portb == 0.
- illegal  out  1  op was an unlisted encoding.

Behaviour:
- Reset (nRST low at a CLK edge):
  - State goes to IDLE.
  - portout, negative, zero, overflow, divzero, illegal, out_valid all go to 0.
  - in_ready is 1 from the cycle after reset deasserts.
- States: IDLE, MUL, DIV, FIX, DONE.
- in_ready = (state == IDLE). An operation is accepted on a CLK edge with in_valid & in_ready. Operands and op are latched at accept; later input changes are ignored.
- Base ops (0–9):
  - IDLE → DONE; latency 1 (out_valid high the cycle after accept).
  - Semantics:
    - shifts use portb[SHW-1:0];
    - SRA is arithmetic;
    - ADD/SUB wrap modulo 2^WIDTH;
    - SLT is signed and SLTU unsigned; both produce 0 or 1.
  - overflow:
    - ADD: operands have the same sign and the result sign differs.
    - SUB: operands have different signs and the result sign differs from porta.
    - All other base ops: 0.
- Illegal op: IDLE → DONE; portout = 0, illegal = 1, zero = 1.
- Multiply:
  - Latch |A| and |B| according to signedness (MUL/MULH signed×signed, MULHSU signed×unsigned, MULHU unsigned×unsigned) and record the result sign.
  - MUL state: WIDTH iterations of shift-add into a 2·WIDTH accumulator.
  - FIX: negate the product if the result sign is negative, then select the field (MUL low WIDTH bits, MULH*/U high WIDTH bits).
  - Then DONE. Latency WIDTH+2 cycles; overflow = 0.
- Divide:
  - DIV state: WIDTH iterations of restoring division on magnitudes.
  - FIX: quotient sign = sign(A) xor sign(B); remainder sign = sign(A).
  - Then DONE. Latency WIDTH+2 cycles.
- Divide special cases (no iteration; IDLE → DONE, latency 1):
  - B == 0: DIV/DIVU give all ones; REM/REMU give A; divzero = 1.
  - Signed A == most-negative and B == −1: DIV gives most-negative, REM gives 0, overflow = 1.
- DONE:
  - out_valid = 1; portout and flags are held stable until out_ready.
  - out_valid & out_ready moves to IDLE; in_ready rises the next cycle (no same-cycle accept).
- negative and zero are derived from the final registered portout in every case.
- flush:
  - In any state, flush forces IDLE at the next edge with out_valid = 0; a pending result is discarded.
  - flush wins over a simultaneous accept or out_ready.
- Reset mid-operation is handled the same as flush; all outputs are cleared.
- Iteration counter is $clog2(WIDTH)+1 bits. Counting stops exactly after WIDTH steps with no wrap.

Test Plan:
- Reset held 2 cycles, then released → all outputs 0, in_ready = 1. ADD 0x7FFFFFFF + 1 → 1 cycle later portout = 0x80000000, overflow = 1, negative = 1.
- MULH 0xFFFFFFFF × 0xFFFFFFFF → out_valid exactly 34 cycles after accept, portout = 0. MUL of the same operands gives portout = 1. MULHU of the same gives 0xFFFFFFFE.
- DIV 0xFFFFFFF9 (−7) / 2 → portout = 0xFFFFFFFD (−3). REM of the same → 0xFFFFFFFF (−1). Both in 34 cycles.
- DIVU 5 / 0 → 1-cycle latency, portout = 0xFFFFFFFF, divzero = 1. DIV 0x80000000 / 0xFFFFFFFF → portout = 0x80000000, overflow = 1.
- Backpressure: hold out_ready = 0 for 5 cycles after a SLT −1 < 1 result → portout = 1 stable, in_ready = 0 throughout. Accepted on release, in_ready rises the next cycle.
- Assert flush 10 cycles into a DIVU → IDLE next cycle, out_valid never rises. The following ADD 2 + 3 returns 5. Repeat with WIDTH = 16: MULHU 0xFFFF × 0xFFFF = 0xFFFE in 18 cycles.

Source files
------------

// File: rtl/alu_md.sv
// alu_md: integer ALU with the RV32M multiply/divide/remainder extension.
//
// Base operations (shifts, add/sub, logic, set-less-than) finish in one
// registered cycle. Multiply and divide iterate one bit per cycle on operand
// magnitudes, then a fix-up cycle restores the sign and picks the field.
// The pipeline talks to the block through a valid/ready handshake, and a
// flush input lets the hazard unit drop whatever is in flight.
//
// Ports:
//   CLK        rising-edge clock
//   nRST       synchronous active-low reset
//   flush      abort the current operation and drop any pending result
//   in_valid   op/porta/portb are valid
//   in_ready   block is idle and can accept an operation
//   op         5-bit operation code (0-9 base ops, 16-23 multiply/divide)
//   porta      operand A (rs1)
//   portb      operand B (rs2); shifts use portb[SHW-1:0]
//   out_valid  portout and flags are valid
//   out_ready  consumer takes the result
//   portout    result
//   negative   portout[WIDTH-1]
//   zero       portout == 0
//   overflow   signed overflow (ADD/SUB, DIV/REM of most-negative by -1)
//   divzero    divide or remainder by zero
//   illegal    op was not a listed encoding
module alu_md #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] porta,
  input  logic [WIDTH-1:0] portb,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] portout,
  output logic             negative,
  output logic             zero,
  output logic             overflow,
  output logic             divzero,
  output logic             illegal
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]    LAST_STEP = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MOST_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

  localparam logic [4:0] OP_SLL  = 5'd0;
  localparam logic [4:0] OP_SRL  = 5'd1;
  localparam logic [4:0] OP_SRA  = 5'd2;
  localparam logic [4:0] OP_ADD  = 5'd3;
  localparam logic [4:0] OP_SUB  = 5'd4;
  localparam logic [4:0] OP_AND  = 5'd5;
  localparam logic [4:0] OP_OR   = 5'd6;
  localparam logic [4:0] OP_XOR  = 5'd7;
  localparam logic [4:0] OP_SLT  = 5'd8;
  localparam logic [4:0] OP_SLTU = 5'd9;

  typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;

  state_t              state_q;
  logic [2:0]          opSel_q;
  logic                negRes_q;
  logic [WIDTH-1:0]    mcand_q;
  logic [2*WIDTH-1:0]  acc_q;
  logic [CW-1:0]       cnt_q;

  logic [SHW-1:0]      shAmt;
  logic [WIDTH-1:0]    sum;
  logic [WIDTH-1:0]    diff;
  logic [WIDTH-1:0]    baseRes;
  logic                baseOvf;

  logic                isMd;
  logic                opLegal;
  logic                isDivOp;
  logic                isRemOp;
  logic                signedA;
  logic                signedB;
  logic                negA;
  logic                negB;
  logic [WIDTH-1:0]    magA;
  logic [WIDTH-1:0]    magB;
  logic                negResD;
  logic [WIDTH-1:0]    acceptRes;
  logic                acceptOvf;
  logic                acceptDz;
  logic                acceptIll;
  logic                startIter;

  logic [WIDTH-1:0]    addend;
  logic [WIDTH:0]      mulSum;
  logic [2*WIDTH-1:0]  mulNext;
  logic [WIDTH:0]      trial;
  logic                divFits;
  logic [WIDTH-1:0]    remNext;
  logic [2*WIDTH-1:0]  divNext;

  logic [2*WIDTH-1:0]  prod;
  logic [WIDTH-1:0]    mulField;
  logic [WIDTH-1:0]    divVal;
  logic [WIDTH-1:0]    divField;
  logic [WIDTH-1:0]    fixRes;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);

  // Single-cycle base operations, computed straight from the input operands
  // so the result can be registered on the accepting edge.
  always_comb begin
    shAmt   = portb[SHW-1:0];
    sum     = porta + portb;
    diff    = porta - portb;
    baseRes = '0;
    baseOvf = 1'b0;
    case (op)
      OP_SLL:  baseRes = porta << shAmt;
      OP_SRL:  baseRes = porta >> shAmt;
      OP_SRA:  baseRes = $signed(porta) >>> shAmt;
      OP_ADD: begin
        baseRes = sum;
        baseOvf = (porta[WIDTH-1] == portb[WIDTH-1]) && (sum[WIDTH-1] != porta[WIDTH-1]);
      end
      OP_SUB: begin
        baseRes = diff;
        baseOvf = (porta[WIDTH-1] != portb[WIDTH-1]) && (diff[WIDTH-1] != porta[WIDTH-1]);
      end
      OP_AND:  baseRes = porta & portb;
      OP_OR:   baseRes = porta | portb;
      OP_XOR:  baseRes = porta ^ portb;
      OP_SLT:  baseRes = {{(WIDTH-1){1'b0}}, $signed(porta) < $signed(portb)};
      OP_SLTU: baseRes = {{(WIDTH-1){1'b0}}, porta < portb};
      default: ;
    endcase
  end

  // Accept-time decode. Within the M group op[2] selects divide, op[1:0]
  // picks the variant; signedness per operand follows from that. Everything
  // that finishes without iterating (base ops, illegal codes, divide by
  // zero, most-negative / -1) is resolved here into one immediate result.
  always_comb begin
    isMd     = (op[4:3] == 2'b10);
    opLegal  = isMd || (op <= OP_SLTU);
    isDivOp  = op[2];
    isRemOp  = op[2] & op[1];
    signedA  = op[2] ? ~op[0] : (op[1:0] != 2'b11);
    signedB  = op[2] ? ~op[0] : ~op[1];
    negA     = signedA & porta[WIDTH-1];
    negB     = signedB & portb[WIDTH-1];
    magA     = negA ? -porta : porta;
    magB     = negB ? -portb : portb;
    negResD  = isRemOp ? negA : (negA ^ negB);

    acceptRes = baseRes;
    acceptOvf = baseOvf;
    acceptDz  = 1'b0;
    acceptIll = 1'b0;
    startIter = 1'b0;
    if (!opLegal) begin
      acceptRes = '0;
      acceptOvf = 1'b0;
      acceptIll = 1'b1;
    end else if (isMd) begin
      acceptOvf = 1'b0;
      if (isDivOp && (portb == '0)) begin
        acceptRes = isRemOp ? porta : '1;
        acceptDz  = 1'b1;
      end else if (isDivOp && ~op[0] && (porta == MOST_NEG) && (portb == '1)) begin
        acceptRes = isRemOp ? '0 : MOST_NEG;
        acceptOvf = 1'b1;
      end else begin
        startIter = 1'b1;
      end
    end
  end

  // One iteration step for each long operation. The accumulator holds
  // {high, low}: for multiply the low half starts as the multiplier and the
  // partial product shifts in from the top; for divide the low half starts
  // as the dividend, the high half is the running remainder, and quotient
  // bits shift in at the bottom. The remainder is always below the divisor,
  // so the trial subtraction fits in WIDTH bits.
  always_comb begin
    addend  = acc_q[0] ? mcand_q : '0;
    mulSum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    mulNext = {mulSum, acc_q[WIDTH-1:1]};

    trial   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    divFits = (trial >= {1'b0, mcand_q});
    remNext = divFits ? (trial[WIDTH-1:0] - mcand_q) : trial[WIDTH-1:0];
    divNext = {remNext, acc_q[WIDTH-2:0], divFits};
  end

  // Sign fix-up and field select after the iterations complete.
  always_comb begin
    prod     = negRes_q ? -acc_q : acc_q;
    mulField = (opSel_q[1:0] == 2'b00) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
    divVal   = opSel_q[1] ? acc_q[2*WIDTH-1:WIDTH] : acc_q[WIDTH-1:0];
    divField = negRes_q ? -divVal : divVal;
    fixRes   = opSel_q[2] ? divField : mulField;
  end

  // Control FSM with registered result and flags. Reset clears everything;
  // flush only returns to IDLE (out_valid drops with it) and outranks any
  // accept or result handshake in the same cycle.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q  <= IDLE;
      opSel_q  <= '0;
      negRes_q <= 1'b0;
      mcand_q  <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      portout  <= '0;
      negative <= 1'b0;
      zero     <= 1'b0;
      overflow <= 1'b0;
      divzero  <= 1'b0;
      illegal  <= 1'b0;
    end else if (flush) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            opSel_q  <= op[2:0];
            negRes_q <= negResD;
            cnt_q    <= '0;
            if (startIter) begin
              if (isDivOp) begin
                acc_q   <= {{WIDTH{1'b0}}, magA};
                mcand_q <= magB;
                state_q <= DIV;
              end else begin
                acc_q   <= {{WIDTH{1'b0}}, magB};
                mcand_q <= magA;
                state_q <= MUL;
              end
            end else begin
              portout  <= acceptRes;
              negative <= acceptRes[WIDTH-1];
              zero     <= (acceptRes == '0);
              overflow <= acceptOvf;
              divzero  <= acceptDz;
              illegal  <= acceptIll;
              state_q  <= DONE;
            end
          end
        end
        MUL: begin
          acc_q <= mulNext;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_STEP) state_q <= FIX;
        end
        DIV: begin
          acc_q <= divNext;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_STEP) state_q <= FIX;
        end
        FIX: begin
          portout  <= fixRes;
          negative <= fixRes[WIDTH-1];
          zero     <= (fixRes == '0);
          overflow <= 1'b0;
          divzero  <= 1'b0;
          illegal  <= 1'b0;
          state_q  <= DONE;
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
